// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Registered tx/busy/done with a busy/done handshake toward the upstream sequencer.
module uart_tx_serializer #(
    parameter int unsigned FREQ   = 27000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned CLKS   = FREQ / BAUD,
    parameter int unsigned PARITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW      = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam logic [CW-1:0] LAST  = CW'(CLKS - 1);
    localparam logic       HAS_PAR  = (PARITY != 0);
    localparam logic       ODD_PAR  = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrap;

    assign wrap = (baud_q == LAST);
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state logic; tx_d is the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = wrap ? '0 : CW'(baud_q + 1'b1);
        end

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shift_d = data;
                    par_d   = (^data) ^ ODD_PAR;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (wrap) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (wrap) begin
                    shift_d = shift_q >> 1;
                    bit_d   = 3'(bit_q + 3'd1);
                    if (bit_q == 3'd7) begin
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                        tx_d    = HAS_PAR ? par_q : 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (wrap) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (wrap) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no/even/odd parity) checked every cycle
// against a frame-level model, plus literal expectations for 8'h41 frames.
module tb_uart_tx_serializer;

    localparam int C = 234;  // 27000000 / 115200

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       clr = 1'b0;
    logic       tx_w [3];
    logic       busy_w [3];
    logic       done_w [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_serializer #(.PARITY(g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .data  (data),
            .tx    (tx_w[g]),
            .busy  (busy_w[g]),
            .done  (done_w[g])
        );
    end

    // Frame model: an active frame is a bit vector plus a cycle position.
    logic        m_act  [3] = '{default: 1'b0};
    logic        m_done [3] = '{default: 1'b0};
    int          m_pos  [3] = '{default: 0};
    logic [10:0] m_bits [3] = '{default: '1};

    function automatic int nbits(input int p);
        return (p == 0) ? 10 : 11;
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input int p);
        logic [10:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (p == 1) b[9] = ^d;
        if (p == 2) b[9] = ~(^d);
        return b;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                m_act[p]  <= 1'b0;
                m_done[p] <= 1'b0;
                m_pos[p]  <= 0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                m_done[p] <= 1'b0;
                if (m_act[p]) begin
                    if (m_pos[p] == nbits(p) * C - 1) begin
                        m_act[p]  <= 1'b0;
                        m_done[p] <= 1'b1;
                    end else begin
                        m_pos[p] <= m_pos[p] + 1;
                    end
                end else if (start) begin
                    m_act[p]  <= 1'b1;
                    m_pos[p]  <= 0;
                    m_bits[p] <= frame_bits(data, p);
                end
            end
        end
    end

    task automatic check(input string nm, input int p, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got=%b want=%b at %0t", nm, p, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int p, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, p, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            check("tx",   p, tx_w[p],   m_act[p] ? m_bits[p][m_pos[p] / C] : 1'b1);
            check("busy", p, busy_w[p], m_act[p]);
            check("done", p, done_w[p], m_done[p]);
        end
    end

    // Activity counters for frame-length and handshake checks.
    int   busy_cnt [3];
    int   done_cnt [3];
    int   first_done [3];
    int   last_rise [3];
    logic bprev [3] = '{default: 1'b0};
    int   cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int p = 0; p < 3; p++) begin
            bprev[p] <= busy_w[p];
            if (clr) begin
                busy_cnt[p]   <= 0;
                done_cnt[p]   <= 0;
                first_done[p] <= -1;
                last_rise[p]  <= -1;
            end else begin
                if (busy_w[p]) busy_cnt[p] <= busy_cnt[p] + 1;
                if (done_w[p]) done_cnt[p] <= done_cnt[p] + 1;
                if (done_w[p] && done_cnt[p] == 0) first_done[p] <= cyc;
                if (busy_w[p] && !bprev[p]) last_rise[p] <= cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic clear_counters();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_w[0] | busy_w[1] | busy_w[2]) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 0, n < budget, 1'b1);
        wait_cyc(2);
    endtask

    logic [9:0] exp41;

    initial begin
        exp41 = 10'b10_1000_0010;  // bit k = tx at centre of bit k, for 8'h41 8N1
        #1 rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            start = ~start;
            data  = data + 8'h3C;
        end
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check("rst_tx", p, tx_w[p], 1'b1);
            check("rst_busy", p, busy_w[p], 1'b0);
        end
        rst = 1'b1;
        wait_cyc(3);

        // Single frame 8'h41 with a rejected start mid-frame.
        clear_counters();
        start = 1'b1;
        data  = 8'h41;
        wait_cyc(1);
        wait_cyc(C / 2);
        for (int k = 0; k < 11; k++) begin
            if (k < 10) check("bit41", k, tx_w[0], exp41[k]);
            if (k == 9) begin
                check("par_even", 1, tx_w[1], 1'b0);
                check("par_odd",  2, tx_w[2], 1'b1);
            end
            if (k == 10) check("stop_par", 1, tx_w[1], 1'b1);
            if (k == 2) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            if (k < 10) wait_cyc(C);
        end
        wait_idle(3000);
        check_int("len_8n1", 0, busy_cnt[0], 2340);
        check_int("len_par", 1, busy_cnt[1], 2574);
        check_int("len_par", 2, busy_cnt[2], 2574);
        for (int p = 0; p < 3; p++) check_int("done_once", p, done_cnt[p], 1);

        // Back-to-back frames with start held high.
        clear_counters();
        start = 1'b1;
        data  = 8'h55;
        @(posedge clk);
        #1;
        data = 8'hAA;
        repeat (2600) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(3000);
        check_int("b2b_busy", 0, busy_cnt[0], 4680);
        check_int("b2b_done", 0, done_cnt[0], 2);
        check_int("b2b_gap",  0, last_rise[0] - first_done[0], 1);
        check_int("b2b_busy", 1, busy_cnt[1], 5148);
        check_int("b2b_done", 2, done_cnt[2], 2);

        // Reset mid-frame, then a clean frame.
        start = 1'b1;
        data  = 8'h41;
        wait_cyc(1000);
        rst = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            check("midrst_tx", p, tx_w[p], 1'b1);
            check("midrst_busy", p, busy_w[p], 1'b0);
        end
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(3);
        clear_counters();
        start = 1'b1;
        data  = 8'h41;
        wait_cyc(1);
        wait_idle(3000);
        check_int("post_rst_len", 0, busy_cnt[0], 2340);
        check_int("post_rst_len", 2, busy_cnt[2], 2574);
        check_int("post_rst_done", 0, done_cnt[0], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
